// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding, sizes and reset pointer.
package mux_arb_pkg;

    localparam int unsigned ARB_N  = 8;
    localparam int unsigned ARB_SW = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Pointer starts at the last index so requester 0 is searched first after reset.
    localparam logic [ARB_SW-1:0] PTR_RESET = 3'd7;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request after ptr, searching ptr+1 .. ptr+8 mod 8.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [ARB_N-1:0]  req,
    input  logic [ARB_SW-1:0] ptr,
    output logic              any,
    output logic [ARB_SW-1:0] win,
    output logic [ARB_N-1:0]  win_oh
);

    logic [ARB_SW-1:0] idx;

    always_comb begin
        any    = 1'b0;
        win    = ptr;
        idx    = ptr;
        win_oh = '0;
        // The last probe (i == ARB_N) wraps to ptr itself, so the previous owner ranks last.
        for (int unsigned i = 1; i <= ARB_N; i++) begin
            idx = ptr + ARB_SW'(i);
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
        if (any) begin
            win_oh = ARB_N'(1) << win;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing an 8:1 bit mux; registers d[sel] of the owner onto y.
// Optional hold timeout with forced release is compiled in by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned SW       = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] sel,
    output logic          valid,
    output logic          y
);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          y_q, y_d;

    logic          any;
    logic [SW-1:0] win;
    logic [N-1:0]  win_oh;
    logic          force_rel;

    rr_pick u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (any),
        .win    (win),
        .win_oh (win_oh)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Only preempt the owner when someone else is actually waiting.
    assign force_rel = (cnt_q == CNT_MAX) && (|(req & ~grant_q));
`else
    logic unused_max_hold;

    assign force_rel       = 1'b0;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        y_d     = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (any) begin
                    state_d = ARB_GRANT;
                    grant_d = win_oh;
                    sel_d   = win;
                    ptr_d   = win;
`ifdef MUX_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ARB_GRANT: begin
                if (!req[sel_q] || force_rel) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end else begin
                    y_d = d[sel_q];
`ifdef MUX_ARB_TIMEOUT_EN
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= PTR_RESET;
            sel_q   <= '0;
            grant_q <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            y_q     <= y_d;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = (state_q == ARB_GRANT);
    assign y     = y_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter against a cycle-level behavioural model of the arbiter.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       y;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: owner index (-1 when idle), last winner, visible sel, cycles held, y.
    int         m_owner;
    int         m_last;
    int         m_sel;
    int         m_held;
    logic       m_y;
    logic [7:0] eg;

    always #5 clk = ~clk;

    mux_rr_arbiter #(
        .N        (8),
        .SW       (3),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d     (d),
        .grant (grant),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_sel   = 0;
        m_held  = 0;
        m_y     = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic [7:0] dd);
        logic [7:0] others;
        if (m_owner < 0) begin
            m_y = 1'b0;
            if (r != 8'h00) begin
                for (int k = 1; k <= 8; k++) begin
                    int c;
                    c = (m_last + k) % 8;
                    if (r[c]) begin
                        m_owner = c;
                        m_last  = c;
                        m_sel   = c;
                        m_held  = 1;
                        break;
                    end
                end
            end
        end else begin
            others = r & ~(8'(1) << m_owner);
            if (!r[m_owner] || (TIMEOUT && m_held >= MAX_HOLD && others != 8'h00)) begin
                m_owner = -1;
                m_y     = 1'b0;
            end else begin
                m_y    = dd[m_owner];
                m_held = m_held + 1;
            end
        end
        eg = (m_owner < 0) ? 8'h00 : (8'(1) << m_owner);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(req, d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        d   = 8'h00;
        model_reset();
        eg = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'h00;
        d   = 8'hFF;
        model_reset();
        #12;
        vectors++;
        if ({grant, sel, valid, y} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_values: grant=%b sel=%0d valid=%b y=%b, want all zero",
                     grant, sel, valid, y);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 8'b1000_0001;
        tick();
        vectors++;
        if (grant !== 8'b0000_0001 || sel !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_priority: grant=%b sel=%0d, want grant=00000001 sel=0",
                     grant, sel);
        end
        req = 8'b1000_0000;
        tick();
        vectors++;
        if (valid !== 1'b0 || grant !== 8'h00) begin
            miscompares++;
            $display("FAIL release_bubble: grant=%b valid=%b, want grant=00000000 valid=0",
                     grant, valid);
        end
        tick();
        vectors++;
        if (grant !== 8'b1000_0000 || sel !== 3'd7) begin
            miscompares++;
            $display("FAIL second_grant: grant=%b sel=%0d, want grant=10000000 sel=7",
                     grant, sel);
        end
    endtask

    task automatic test_round_robin();
        int   got[$];
        logic prev_valid;
        do_reset();
        prev_valid = 1'b0;
        req = 8'hFF;
        for (int cyc = 0; cyc < 60 && got.size() < 9; cyc++) begin
            d = 8'($urandom);
            tick();
            vectors++;
            if ({grant, sel, valid, y} !== {eg, 3'(m_sel), (m_owner >= 0), m_y}) begin
                miscompares++;
                $display("FAIL rr_cycle%0d: grant=%b sel=%0d valid=%b y=%b want %b %0d %b %b",
                         cyc, grant, sel, valid, y, eg, m_sel, (m_owner >= 0), m_y);
            end
            if (valid && !prev_valid) got.push_back(int'(sel));
            prev_valid = valid;
            req = (m_owner >= 0 && m_held == 3) ? ~(8'(1) << m_owner) : 8'hFF;
        end
        vectors++;
        if (got.size() != 9) begin
            miscompares++;
            $display("FAIL rr_count: grants seen=%0d, want 9", got.size());
        end
        foreach (got[i]) begin
            vectors++;
            if (got[i] != i % 8) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: owner=%0d, want %0d", i, got[i], i % 8);
            end
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_datapath();
        logic [7:0] dseq[4] = '{8'h00, 8'b0010_0000, 8'b0000_0000, 8'b1101_1111};
        logic       yexp[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        req = 8'b0010_0000;
        d   = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) d = dseq[i];
            tick();
            vectors++;
            if (y !== yexp[i] || {grant, sel, valid, y} !== {eg, 3'(m_sel), (m_owner >= 0), m_y}) begin
                miscompares++;
                $display("FAIL datapath_step%0d: grant=%b sel=%0d y=%b, want grant=%b sel=%0d y=%b",
                         i, grant, sel, y, eg, m_sel, yexp[i]);
            end
        end
        req = 8'h00;
        d   = 8'hFF;
        tick();
        vectors++;
        if (y !== 1'b0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL datapath_idle: y=%b valid=%b, want y=0 valid=0", y, valid);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] want;
        do_reset();
        req = 8'b0000_0100;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            tick();
            vectors++;
            if ({grant, sel, valid, y} !== {eg, 3'(m_sel), (m_owner >= 0), m_y}) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: grant=%b sel=%0d valid=%b y=%b want %b %0d %b %b",
                         i, grant, sel, valid, y, eg, m_sel, (m_owner >= 0), m_y);
            end
        end
        vectors++;
        if (grant !== 8'b0000_0100) begin
            miscompares++;
            $display("FAIL hold_persist: grant=%b, want 00000100", grant);
        end
        req = 8'b0100_0100;
        tick();
        tick();
        want = TIMEOUT ? 8'b0100_0000 : 8'b0000_0100;
        vectors++;
        if (grant !== want || grant !== eg) begin
            miscompares++;
            $display("FAIL contend: grant=%b, want %b", grant, want);
        end
        req = 8'b0100_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({grant, sel, valid, y} !== {eg, 3'(m_sel), (m_owner >= 0), m_y}) begin
                miscompares++;
                $display("FAIL handover%0d: grant=%b sel=%0d valid=%b y=%b want %b %0d %b %b",
                         i, grant, sel, valid, y, eg, m_sel, (m_owner >= 0), m_y);
            end
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req = 8'($urandom) & 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) req[m_owner] = 1'b1;
            d = 8'($urandom);
            tick();
            vectors++;
            if ({grant, sel, valid, y} !== {eg, 3'(m_sel), (m_owner >= 0), m_y}) begin
                miscompares++;
                $display("FAIL random%0d: grant=%b sel=%0d valid=%b y=%b want %b %0d %b %b",
                         i, grant, sel, valid, y, eg, m_sel, (m_owner >= 0), m_y);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'b0001_0000;
        d   = 8'hFF;
        tick();
        tick();
        tick();
        vectors++;
        if (grant !== 8'b0001_0000 || y !== 1'b1) begin
            miscompares++;
            $display("FAIL premid_grant: grant=%b y=%b, want grant=00010000 y=1", grant, y);
        end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({grant, sel, valid, y} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_mid: grant=%b sel=%0d valid=%b y=%b, want all zero",
                     grant, sel, valid, y);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 8'hFF;
        tick();
        vectors++;
        if (grant !== 8'b0000_0001 || sel !== 3'd0 || grant !== eg) begin
            miscompares++;
            $display("FAIL after_reset_mid: grant=%b sel=%0d, want grant=00000001 sel=0",
                     grant, sel);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_datapath();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

- Round-robin arbiter that shares one 8:1 bit multiplexer between eight requesters.
- Each requester owns one data bit of `d`. The block grants one requester at a time, drives the 3-bit mux select, and registers the selected bit onto `y`.
- It sits in front of the 8-way mux datapath and replaces the free-running select counter used by the lab benches.

## Interface

Parameters:
- `N`, 8: number of requesters; fixed at 8.
- `SW`, 3: select width, log2(N).
- `MAX_HOLD`, 16: maximum grant length in cycles when timeout is compiled in; legal range 2..16.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 8: request per requester; level, held until served.
- `d`, input, 8: data bit per requester.
- `grant`, output, 8: one-hot grant; all zero when idle.
- `sel`, output, 3: index of the current owner; holds the last owner while idle.
- `valid`, output, 1: high while a grant is active; equals `|grant`.
- `y`, output, 1: registered `d[sel]` of the current owner; 0 when not valid.

## Operation

- There are two states, IDLE and GRANT.
- Round-robin pointer `ptr` (3 bits) holds the last granted index.
  - Search order is `ptr+1`, `ptr+2`, … modulo 8, wrapping 7→0.
  - The first asserted `req` in that order wins.
- **IDLE → GRANT** when `req != 0`:
  - `grant[w]` is set, `sel` becomes w, and `ptr` becomes w on the same edge.
  - The hold counter `cnt` clears to 0.
- **GRANT → IDLE** when `req[sel]` is sampled low:
  - This is a voluntary release.
  - `grant` clears and `sel` is kept.
- **Forced release (only with timeout compiled in):**
  - Occurs when `cnt == MAX_HOLD-1` and any other `req` bit is high.
  - The block goes GRANT → IDLE even though `req[sel]` is still high.
  - With no competing request, `cnt` saturates at `MAX_HOLD-1` and the grant persists.
- **Re-request:** a released requester that still requests competes normally. Round-robin places it last.
- **Idle `y`:** in IDLE, `y` is 0.
- **Reset values:** `grant`=0, `sel`=0, `valid`=0, `y`=0, `ptr`=7 (so index 0 has first priority), `cnt`=0, state IDLE.
- **Reset mid-grant:** all of the above apply immediately (asynchronously). There is no release handshake.
- **Unknown `req` bits:** treated as don't-care by the bench only; the RTL takes no special action.

## Timing

- **Grant latency:** a `req` sampled high in IDLE gives `grant`/`valid` one cycle later.
- **Release latency:** a `req[sel]` sampled low drops `grant` one cycle later.
- **Bubble:** there is always exactly one IDLE cycle between consecutive grants. Back-to-back throughput is one grant per (hold + 1) cycles.
- **Data latency:** `y` at edge k+1 equals `d[sel]` sampled at edge k while the block is in GRANT. On the first GRANT cycle `y` is still 0.
- **Simultaneous requests:** the pointer order decides; there is no fixed priority after reset.
- **Release and new request in the same cycle:** the release is taken. The new request is evaluated in the following IDLE cycle.

## Configuration

- Macro: `MUX_ARB_TIMEOUT_EN`.
- **Defined:** `cnt` and the forced-release path are compiled in, as described in Operation.
- **Undefined:**
  - No counter exists.
  - An owner keeps the grant until it drops `req`.
  - `MAX_HOLD` is ignored.

## Structure

- **Shared package `mux_arb_pkg`:** holds the state encoding (`ARB_IDLE`=1'b0, `ARB_GRANT`=1'b1), `N`/`SW` constants, and the reset pointer value 3'd7.
- **Sub-module `rr_pick`:** combinational, taking `req[7:0]` and `ptr[2:0]` and returning `any`, `win[2:0]`, and one-hot `win_oh[7:0]`.
- **Top:** holds the FSM, pointer, counter, and the `y` register. The `y` register uses the 8:1 select `d[sel]`.

## Test plan

- **Reset priority:** reset, then `req`=8'b1000_0001 → after one cycle `grant`=8'b0000_0001, `sel`=0. Drop `req[0]` → one IDLE cycle, then `grant`=8'b1000_0000, `sel`=7.
- **Round-robin fairness:** `req`=8'hFF held, each owner drops its bit for one cycle after 3 grant cycles → grant order 0,1,2,…,7,0, each separated by one `valid`=0 cycle.
- **Datapath:** owner 5 granted, `d`=8'b0010_0000 then 8'b0000_0000 → `y`=1 then 0, each one cycle after `d`; `y`=0 in IDLE.
- **Timeout (macro defined, `MAX_HOLD`=4):**
  - `req[2]` alone held → grant persists beyond 10 cycles.
  - Then raise `req[6]` → `grant[2]` drops once `cnt` reaches 3, and `grant[6]` follows one IDLE cycle later.
- **No timeout (macro undefined):** same stimulus → `grant[2]` stays until `req[2]` drops.
- **Reset mid-grant:** assert `rst` between clock edges during a grant → `grant`, `valid`, `y`, and `sel` are 0 immediately. After release, `req`=8'hFF grants index 0.
